// File: rtl/booth_mul_seq.sv
// booth_mul_seq: sequential radix-4 Booth signed multiplier, one Booth group per clock.
// Optional macro BOOTH_EARLY_TERM_EN ends RUN as soon as every remaining group is zero.
module booth_mul_seq #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  input  logic [BITS-1:0] multiplicand,
  input  logic [BITS-1:0] multiplier,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] hi,
  output logic [BITS-1:0] lo
);
  localparam int PW    = 2 * BITS;
  localparam int CNT_W = (BITS / 2 > 1) ? $clog2(BITS / 2) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BITS / 2 - 1);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t state;

  logic signed [BITS-1:0] m_reg;
  logic signed [BITS-1:0] q_reg;
  logic signed [PW-1:0]   m_sh;
  logic signed [PW-1:0]   acc;
  logic signed [PW-1:0]   pp;
  logic signed [PW-1:0]   sum;
  logic signed [BITS:0]   q_sh;
  logic [CNT_W-1:0]       cnt;
  logic                   last_grp;

  // m is already weighted by 4^j, so the selected term adds straight into acc.
  function automatic logic signed [PW-1:0] booth_pp(input logic [2:0] grp,
                                                   input logic signed [PW-1:0] m);
    case (grp)
      3'b001, 3'b010: booth_pp = m;
      3'b011:         booth_pp = m <<< 1;
      3'b100:         booth_pp = -(m <<< 1);
      3'b101, 3'b110: booth_pp = -m;
      default:        booth_pp = '0;
    endcase
  endfunction

`ifdef BOOTH_EARLY_TERM_EN
  // Uniform remaining multiplier bits make every later group 000 or 111.
  function automatic logic rest_uniform(input logic [BITS-2:0] rest);
    rest_uniform = (rest == '0) || (rest == '1);
  endfunction
`endif

  always_comb begin
    pp  = booth_pp(q_sh[2:0], m_sh);
    sum = acc + pp;
`ifdef BOOTH_EARLY_TERM_EN
    last_grp = (cnt == LAST) || rest_uniform(q_sh[BITS:2]);
`else
    last_grp = (cnt == LAST);
`endif
  end

  // q_sh holds {Q, q[-1]} shifted right two bits per group; bits [2:0] are the current group.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      m_reg <= '0;
      q_reg <= '0;
      m_sh  <= '0;
      q_sh  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= multiplicand;
            q_reg <= multiplier;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          acc   <= '0;
          cnt   <= '0;
          m_sh  <= {{BITS{m_reg[BITS-1]}}, m_reg};
          q_sh  <= {q_reg, 1'b0};
          state <= RUN;
        end
        RUN: begin
          acc  <= sum;
          m_sh <= m_sh <<< 2;
          q_sh <= q_sh >>> 2;
          cnt  <= cnt + 1'b1;
          if (last_grp) begin
            hi    <= sum[PW-1:BITS];
            lo    <= sum[BITS-1:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_booth_mul_seq.sv
// Scoreboard bench for booth_mul_seq (BITS=32): products, latency, busy/done timing, abort.
module tb_booth_mul_seq;
  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic [31:0] multiplicand = '0;
  logic [31:0] multiplier = '0;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  booth_mul_seq #(.BITS(32)) dut (
    .clk(clk), .clr(clr), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Cycle in which done is expected (start accepted at edge 0, LOAD is cycle 1).
  function automatic int model_lat(input logic [31:0] q);
    int el;
    el = 18;
    for (int j = 15; j >= 0; j--) begin
      bit uni;
      uni = 1'b1;
      for (int b = 2 * j + 1; b < 32; b++)
        if (q[b] != q[2 * j + 1]) uni = 1'b0;
      if (uni) el = j + 3;
    end
`ifdef BOOTH_EARLY_TERM_EN
    return el;
`else
    return (el > 0) ? 18 : 18;
`endif
  endfunction

  // Called at #1 after a rising edge with the DUT idle; returns one cycle after DONE.
  task automatic run_op(input logic [31:0] m, input logic [31:0] q, input bit inject);
    exp_t   e;
    exp_t   got;
    longint p;
    int     c;
    int     busy_cnt;
    bit     hold_ok;
    bit     seen;
    p = longint'($signed(m)) * longint'($signed(q));
    e.hi  = p[63:32];
    e.lo  = p[31:0];
    e.lat = model_lat(q);
    sb.push_back(e);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    multiplicand = $urandom;
    multiplier   = $urandom;
    c = 1; busy_cnt = 0; hold_ok = 1'b1; seen = 1'b0;
    while (c < 40 && !seen) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        if (busy === 1'b1) busy_cnt++;
        if (hi !== last_hi || lo !== last_lo) hold_ok = 1'b0;
        if (inject && (c == 5 || c == 6)) begin
          start = 1'b1; multiplicand = 32'h1111_1111; multiplier = 32'h2222_2222;
        end else start = 1'b0;
        @(posedge clk); #1;
        c++;
      end
    end
    start = 1'b0;
    total++;
    if (!seen) begin bad++; $display("FAIL timeout: no done within %0d cycles", c); end
    if (sb.size() > 0) got = sb.pop_front(); else got = e;
    total++;
    if (hi !== got.hi) begin bad++; $display("FAIL hi: got %h want %h", hi, got.hi); end
    total++;
    if (lo !== got.lo) begin bad++; $display("FAIL lo: got %h want %h", lo, got.lo); end
    total++;
    if (c !== got.lat) begin bad++; $display("FAIL latency: got %0d want %0d", c, got.lat); end
    total++;
    if (busy_cnt !== got.lat - 1) begin
      bad++; $display("FAIL busy_cycles: got %0d want %0d", busy_cnt, got.lat - 1);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL busy_at_done: got %b want 0", busy); end
    total++;
    if (!hold_ok) begin bad++; $display("FAIL hold: hi/lo changed before done, want %h_%h", last_hi, last_lo); end
    last_hi = got.hi;
    last_lo = got.lo;
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL done_pulse: got %b want 0", done); end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL rst_hi: got %h want 0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL rst_lo: got %h want 0", lo); end
    clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_products;
    run_op(32'd3, 32'd5, 1'b0);
    total++; if ({hi, lo} !== 64'h0000_0000_0000_000F) begin
      bad++; $display("FAIL prod_3x5: got %h%h want 000000000000000f", hi, lo); end
    run_op(-32'sd7, 32'd6, 1'b0);
    total++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFD6) begin
      bad++; $display("FAIL prod_m7x6: got %h%h want ffffffffffffffd6", hi, lo); end
    run_op(32'd6, -32'sd7, 1'b0);
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0);
    total++; if ({hi, lo} !== 64'h4000_0000_0000_0000) begin
      bad++; $display("FAIL prod_minxmin: got %h%h want 4000000000000000", hi, lo); end
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
    total++; if ({hi, lo} !== 64'hC000_0000_8000_0000) begin
      bad++; $display("FAIL prod_maxxmin: got %h%h want c000000080000000", hi, lo); end
    run_op(32'h0, 32'hFFFF_FFFF, 1'b0);
    for (int i = 0; i < 6; i++) run_op($urandom, $urandom, 1'b0);
  endtask

  task automatic test_ignore_start;
    int extra;
    run_op(32'h0001_2345, 32'h7654_3210, 1'b1);
    extra = 0;
    for (int i = 0; i < 25; i++) begin
      if (done === 1'b1 || busy === 1'b1) extra++;
      @(posedge clk); #1;
    end
    total++;
    if (extra !== 0) begin bad++; $display("FAIL ignored_start: got %0d active cycles want 0", extra); end
  endtask

  task automatic test_abort;
    int dones;
    multiplicand = 32'h0BAD_CAFE;
    multiplier   = 32'h7123_4567;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #4;
    clr = 1'b1;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
    total++; if (hi !== 32'h0 || lo !== 32'h0) begin
      bad++; $display("FAIL abort_hilo: got %h_%h want 0_0", hi, lo); end
    @(posedge clk); #1;
    clr = 1'b0;
    last_hi = '0;
    last_lo = '0;
    dones = 0;
    for (int i = 0; i < 25; i++) begin
      if (done === 1'b1) dones++;
      @(posedge clk); #1;
    end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL abort_done: got %0d pulses want 0", dones); end
    run_op(32'd2, 32'd3, 1'b0);
    total++; if (lo !== 32'd6) begin bad++; $display("FAIL after_abort_lo: got %h want 6", lo); end
  endtask

  task automatic test_early_term;
    run_op(32'h1234_5678, 32'd1, 1'b0);
    total++; if (lo !== 32'h1234_5678 || hi !== 32'h0) begin
      bad++; $display("FAIL early_q1: got %h_%h want 00000000_12345678", hi, lo); end
    run_op(32'h1234_5678, 32'hFFFF_FFFF, 1'b0);
    run_op(32'hDEAD_BEEF, 32'h0000_0040, 1'b0);
  endtask

  task automatic test_back_to_back;
    run_op(32'd100, 32'd200, 1'b0);
    run_op(-32'sd1, -32'sd1, 1'b0);
    run_op(32'h4000_0000, 32'h0000_0004, 1'b0);
  endtask

  initial begin
    test_reset();
    test_products();
    test_ignore_start();
    test_abort();
    test_early_term();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
